// File: rtl/gf_seq.sv
// gf_seq: serializes a byte stream MSB-first into 2-bit Gaussian-filter symbols with sample strobe and flush tail.
// Define GF_SEQ_PREAMBLE_EN to insert a 32-symbol alternating preamble before the first byte's symbols.
module gf_seq #(
    parameter int unsigned DIV   = 8,
    parameter int unsigned OSR   = 4,
    parameter int unsigned FLUSH = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] len,
    input  logic [7:0] data,
    input  logic       data_valid,
    output logic       data_ready,
    output logic [1:0] gf_x,
    output logic       gf_clk_en,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned DW = (DIV > 1)   ? $clog2(DIV)   : 1;
    localparam int unsigned SW = (OSR > 1)   ? $clog2(OSR)   : 1;
    localparam int unsigned FW = (FLUSH > 1) ? $clog2(FLUSH) : 1;

    localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
    localparam logic [SW-1:0] OSR_LAST   = SW'(OSR - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH - 1);

    localparam logic [1:0] SYM_P = 2'b01;
    localparam logic [1:0] SYM_N = 2'b11;
    localparam logic [1:0] SYM_Z = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
`ifdef GF_SEQ_PREAMBLE_EN
        S_PRE,
`endif
        S_SHIFT,
        S_FLUSH,
        S_FIN
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [SW-1:0] samp_cnt_q, samp_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    pf_q, pf_d;
    logic          pf_full_q, pf_full_d;
    logic [7:0]    bytes_left_q, bytes_left_d;
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;
    logic          err_flag_q, err_flag_d;
    logic [1:0]    gf_x_q, gf_x_d;
    logic          gf_clk_en_q, gf_clk_en_d;
`ifdef GF_SEQ_PREAMBLE_EN
    logic [4:0]    pre_cnt_q, pre_cnt_d;
`endif

    logic hs;
    logic tick;
    logic sym_end;

    function automatic logic [1:0] sym_of(input logic b);
        return b ? SYM_P : SYM_N;
    endfunction

    function automatic logic is_ticking(input state_t s);
        logic r;
        r = (s == S_SHIFT) || (s == S_FLUSH);
`ifdef GF_SEQ_PREAMBLE_EN
        r = r || (s == S_PRE);
`endif
        return r;
    endfunction

    function automatic logic is_streaming(input state_t s);
        logic r;
        r = (s == S_SHIFT);
`ifdef GF_SEQ_PREAMBLE_EN
        r = r || (s == S_PRE);
`endif
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            div_cnt_q    <= '0;
            samp_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            pf_q         <= '0;
            pf_full_q    <= 1'b0;
            bytes_left_q <= '0;
            flush_cnt_q  <= '0;
            err_flag_q   <= 1'b0;
            gf_x_q       <= SYM_Z;
            gf_clk_en_q  <= 1'b0;
`ifdef GF_SEQ_PREAMBLE_EN
            pre_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            samp_cnt_q   <= samp_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            pf_q         <= pf_d;
            pf_full_q    <= pf_full_d;
            bytes_left_q <= bytes_left_d;
            flush_cnt_q  <= flush_cnt_d;
            err_flag_q   <= err_flag_d;
            gf_x_q       <= gf_x_d;
            gf_clk_en_q  <= gf_clk_en_d;
`ifdef GF_SEQ_PREAMBLE_EN
            pre_cnt_q    <= pre_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        samp_cnt_d   = samp_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        pf_d         = pf_q;
        pf_full_d    = pf_full_q;
        bytes_left_d = bytes_left_q;
        flush_cnt_d  = flush_cnt_q;
        err_flag_d   = err_flag_q;
        gf_x_d       = gf_x_q;
`ifdef GF_SEQ_PREAMBLE_EN
        pre_cnt_d    = pre_cnt_q;
`endif
        hs      = data_valid & data_ready;
        tick    = gf_clk_en_q;
        sym_end = tick && (samp_cnt_q == OSR_LAST);

        if (is_ticking(state_q)) begin
            div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DW'(1);
            if (tick) begin
                samp_cnt_d = (samp_cnt_q == OSR_LAST) ? '0 : samp_cnt_q + SW'(1);
            end
        end else begin
            div_cnt_d  = '0;
            samp_cnt_d = '0;
        end

        if (hs && is_streaming(state_q)) begin
            pf_d         = data;
            pf_full_d    = 1'b1;
            bytes_left_d = bytes_left_q - 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start && (len != '0)) begin
                    state_d      = S_LOAD;
                    bytes_left_d = len;
                    err_flag_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (hs) begin
                    shreg_d      = data;
                    bytes_left_d = bytes_left_q - 8'd1;
                    bit_cnt_d    = '0;
`ifdef GF_SEQ_PREAMBLE_EN
                    state_d      = S_PRE;
                    pre_cnt_d    = '0;
                    gf_x_d       = SYM_P;
`else
                    state_d      = S_SHIFT;
                    gf_x_d       = sym_of(data[7]);
`endif
                end
            end
`ifdef GF_SEQ_PREAMBLE_EN
            S_PRE: begin
                if (sym_end) begin
                    if (pre_cnt_q == 5'd31) begin
                        state_d = S_SHIFT;
                        gf_x_d  = sym_of(shreg_q[7]);
                    end else begin
                        pre_cnt_d = pre_cnt_q + 5'd1;
                        gf_x_d    = pre_cnt_q[0] ? SYM_P : SYM_N;
                    end
                end
            end
`endif
            S_SHIFT: begin
                if (sym_end) begin
                    if (bit_cnt_q != 3'd7) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shreg_d   = {shreg_q[6:0], 1'b0};
                        gf_x_d    = sym_of(shreg_q[6]);
                    end else if (pf_full_q || hs) begin
                        // a byte handshaken on the boundary edge bypasses the prefetch register
                        shreg_d   = pf_full_q ? pf_q : data;
                        pf_full_d = 1'b0;
                        bit_cnt_d = '0;
                        gf_x_d    = sym_of(pf_full_q ? pf_q[7] : data[7]);
                    end else begin
                        state_d     = S_FLUSH;
                        gf_x_d      = SYM_Z;
                        flush_cnt_d = '0;
                        err_flag_d  = (bytes_left_q != '0);
                    end
                end
            end
            S_FLUSH: begin
                if (tick) begin
                    if (flush_cnt_q == FLUSH_LAST) begin
                        state_d = S_FIN;
                    end else begin
                        flush_cnt_d = flush_cnt_q + FW'(1);
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        gf_clk_en_d = is_ticking(state_d) && (div_cnt_d == DIV_LAST);
    end

    always_comb begin
        data_ready = (state_q == S_LOAD) ||
                     (is_streaming(state_q) && !pf_full_q && (bytes_left_q != '0));
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_FIN);
        err        = (state_q == S_FIN) && err_flag_q;
    end

    assign gf_x      = gf_x_q;
    assign gf_clk_en = gf_clk_en_q;

endmodule

// File: tb/tb_gf_seq.sv
// tb_gf_seq: scoreboard bench for gf_seq; expected per-sample symbols come from a byte-level model.
// Honours GF_SEQ_PREAMBLE_EN when defined for both bench and design.
module tb_gf_seq;

    localparam int DIV   = 2;
    localparam int OSR   = 2;
    localparam int FLUSH = 18;
`ifdef GF_SEQ_PREAMBLE_EN
    localparam int PRE_SYMS = 32;
`else
    localparam int PRE_SYMS = 0;
`endif
    // handshake of byte 1 lands exactly on the last tick of byte 0
    localparam int BOUND_GAP = (PRE_SYMS + 8) * OSR * DIV - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] len = '0;
    logic [7:0] data = '0;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic [1:0] gf_x;
    logic       gf_clk_en;
    logic       busy;
    logic       done;
    logic       err;

    gf_seq #(.DIV(DIV), .OSR(OSR), .FLUSH(FLUSH)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .data(data),
        .data_valid(data_valid), .data_ready(data_ready), .gf_x(gf_x),
        .gf_clk_en(gf_clk_en), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] exp_q[$];
    logic       err_q[$];
    logic [7:0] pkt[$];

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: preamble, then each delivered byte MSB-first at OSR samples per bit, then FLUSH zeros.
    task automatic push_model(input int n_del);
        logic [7:0] v;
        for (int k = 0; k < PRE_SYMS; k++)
            for (int s = 0; s < OSR; s++) exp_q.push_back((k % 2 == 0) ? 2'b01 : 2'b11);
        for (int i = 0; i < n_del; i++) begin
            v = pkt[i];
            for (int b = 7; b >= 0; b--)
                for (int s = 0; s < OSR; s++) exp_q.push_back(v[b] ? 2'b01 : 2'b11);
        end
        for (int f = 0; f < FLUSH; f++) exp_q.push_back(2'b00);
        err_q.push_back(n_del < pkt.size());
    endtask

    int  since = 0;
    bit  have_prev = 0;
    bit  prev_done = 0;
    logic [1:0] e;

    always @(negedge clk) begin
        if (rst) begin
            have_prev = 0;
            prev_done = 0;
        end else begin
            if (have_prev) since++;
            if (gf_clk_en) begin
                if (exp_q.size() == 0) chk("unexpected_tick", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("gf_x", int'(gf_x), int'(e));
                end
                if (have_prev) chk("tick_spacing", since, DIV);
                have_prev = 1;
                since = 0;
            end
            if (prev_done) chk("busy_after_done", busy, 0);
            if (done) begin
                if (err_q.size() == 0) chk("unexpected_done", 1, 0);
                else chk("err", err, err_q.pop_front());
                have_prev = 0;
            end
            prev_done = done;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        data = b;
        data_valid = 1'b1;
        n = 0;
        while (!data_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("handshake", data_ready, 1);
        if (data_ready) begin
            @(posedge clk);
            @(negedge clk);
        end
        data_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic [7:0] l);
        @(negedge clk);
        start = 1'b1;
        len = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_packet(input int n_del, input int gap_max, input int fixed_gap, input bit poke);
        int n;
        int g;
        push_model(n_del);
        pulse_start(8'(pkt.size()));
        chk("busy_after_start", busy, 1);
        chk("ready_after_start", data_ready, 1);
        for (int i = 0; i < n_del; i++) begin
            g = (fixed_gap >= 0 && i > 0) ? fixed_gap : int'($urandom_range(gap_max, 0));
            send_byte(pkt[i], g);
            if (i == 0 && poke) begin
                start = 1'b1;
                len = 8'd5;
                @(negedge clk);
                start = 1'b0;
            end
        end
        n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("packet_end", busy, 0);
        if (busy) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
        chk("samples_left", exp_q.size(), 0);
        chk("done_seen", err_q.size(), 0);
        exp_q.delete();
        err_q.delete();
        @(negedge clk);
    endtask

    initial begin
        int L;
        int mode;
        int nd;
        #2 rst = 1'b1;
        #1;
        chk("rst_gf_x", gf_x, 0);
        chk("rst_clk_en", gf_clk_en, 0);
        chk("rst_ready", data_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        pkt = {8'hA5};
        run_packet(1, 0, -1, 0);
        pkt = {8'h00, 8'hFF, 8'h81};
        run_packet(3, 0, -1, 0);
        pkt = {8'h3C, 8'hC3};
        run_packet(1, 0, -1, 0);
        pkt = {8'h96, 8'h5A};
        run_packet(2, 0, BOUND_GAP, 0);
        pkt = {8'h12, 8'h34, 8'h56};
        run_packet(3, 3, -1, 1);

        pulse_start(8'd0);
        chk("len0_busy", busy, 0);
        chk("len0_ready", data_ready, 0);

        pkt = {8'hF0, 8'h0F};
        push_model(2);
        pulse_start(8'd2);
        send_byte(pkt[0], 0);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_gf_x", gf_x, 0);
        chk("abort_clk_en", gf_clk_en, 0);
        chk("abort_ready", data_ready, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err, 0);
        exp_q.delete();
        err_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_idle", busy, 0);
        pkt = {8'h0F};
        run_packet(1, 0, -1, 0);

        for (int r = 0; r < 12; r++) begin
            L = int'($urandom_range(4, 1));
            pkt.delete();
            for (int i = 0; i < L; i++) pkt.push_back(8'($urandom));
            mode = int'($urandom_range(2, 0));
            nd = (mode == 2 && L >= 2) ? int'($urandom_range(L - 1, 1)) : L;
            run_packet(nd, (mode == 1) ? 6 : 0, -1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
